// File: rtl/video_dac_palette.sv
// Palette DAC stage: 4-bit colour index -> 8:8:8 RGB, VGA-DAC style CPU port.
// Optional MONO_TINT_EN adds mono_tint[1:0] monochrome tint bypass.
module video_dac_palette #(
  parameter int COLOUR_BITS = 4,
  parameter int COMP_BITS   = 6
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ce_pix,
  input  logic [COLOUR_BITS-1:0] colour,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   hb_in,
  input  logic                   vb_in,
`ifdef MONO_TINT_EN
  input  logic [1:0]             mono_tint,
`endif
  input  logic                   io_wr,
  input  logic                   io_rd,
  input  logic                   io_sel,
  input  logic [7:0]             io_din,
  output logic [7:0]             io_dout,
  output logic [7:0]             r,
  output logic [7:0]             g,
  output logic [7:0]             b,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   hblank,
  output logic                   vblank
);

  localparam int DEPTH   = 1 << COLOUR_BITS;
  localparam int ENTRY_W = 3 * COMP_BITS;

  typedef logic [COMP_BITS-1:0]   comp_t;
  typedef logic [ENTRY_W-1:0]     entry_t;
  typedef logic [COLOUR_BITS-1:0] idx_t;

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_e;

  // Default grey ramp: index bits repeated MSB-first to fill a component.
  function automatic comp_t grey_comp(input idx_t i);
    comp_t c;
    for (int k = 0; k < COMP_BITS; k++) begin
      c[COMP_BITS-1-k] = i[COLOUR_BITS-1-(k % COLOUR_BITS)];
    end
    return c;
  endfunction

  function automatic logic [7:0] expand(input comp_t c);
    return {c, c[COMP_BITS-1 -: (8-COMP_BITS)]};
  endfunction

  entry_t pal_q [DEPTH];

  phase_e phase_q, phase_d;
  idx_t   index_q, index_d;
  comp_t  stg_r_q, stg_r_d;
  comp_t  stg_g_q, stg_g_d;
  logic [7:0] dout_q, dout_d;

  logic   pal_we;
  entry_t pal_wdata;
  entry_t rd_ent;
  comp_t  rd_comp;
  comp_t  din_comp;

  idx_t s1_col_q;
  logic s1_hs_q, s1_vs_q, s1_hb_q, s1_vb_q;

  logic [7:0] r_q, g_q, b_q;
  logic [7:0] r_d, g_d, b_d;
  logic       hs_q, vs_q, hb_q, vb_q;

  logic unused_din;
  assign unused_din = ^io_din[7:COMP_BITS];

  assign din_comp = io_din[COMP_BITS-1:0];

  always_comb begin
    rd_ent  = pal_q[index_q];
    rd_comp = rd_ent[ENTRY_W-1 -: COMP_BITS];
    unique case (phase_q)
      PH_G:    rd_comp = rd_ent[2*COMP_BITS-1 -: COMP_BITS];
      PH_B:    rd_comp = rd_ent[COMP_BITS-1:0];
      default: rd_comp = rd_ent[ENTRY_W-1 -: COMP_BITS];
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      phase_q <= PH_R;
      index_q <= '0;
      stg_r_q <= '0;
      stg_g_q <= '0;
      dout_q  <= '0;
    end else begin
      phase_q <= phase_d;
      index_q <= index_d;
      stg_r_q <= stg_r_d;
      stg_g_q <= stg_g_d;
      dout_q  <= dout_d;
    end
  end

  // A write wins over a simultaneous read; the read is simply dropped.
  always_comb begin
    phase_d   = phase_q;
    index_d   = index_q;
    stg_r_d   = stg_r_q;
    stg_g_d   = stg_g_q;
    dout_d    = dout_q;
    pal_we    = 1'b0;
    pal_wdata = {stg_r_q, stg_g_q, din_comp};
    unique case (1'b1)
      (io_wr && !io_sel): begin
        index_d = io_din[COLOUR_BITS-1:0];
        phase_d = PH_R;
        stg_r_d = '0;
        stg_g_d = '0;
      end
      (io_wr && io_sel): begin
        unique case (phase_q)
          PH_R: begin
            stg_r_d = din_comp;
            phase_d = PH_G;
          end
          PH_G: begin
            stg_g_d = din_comp;
            phase_d = PH_B;
          end
          PH_B: begin
            pal_we  = 1'b1;
            index_d = index_q + 1'b1;
            phase_d = PH_R;
            stg_r_d = '0;
            stg_g_d = '0;
          end
          default: phase_d = PH_R;
        endcase
      end
      (!io_wr && io_rd && !io_sel): begin
        dout_d = {{(8-COLOUR_BITS){1'b0}}, index_q};
      end
      (!io_wr && io_rd && io_sel): begin
        dout_d = {{(8-COMP_BITS){1'b0}}, rd_comp};
        unique case (phase_q)
          PH_R: phase_d = PH_G;
          PH_G: phase_d = PH_B;
          PH_B: begin
            index_d = index_q + 1'b1;
            phase_d = PH_R;
          end
          default: phase_d = PH_R;
        endcase
      end
      default: begin
        dout_d = dout_q;
      end
    endcase
  end

  // Whole entry lands in one edge, so a lookup never sees a torn entry.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        pal_q[e] <= {3{grey_comp(idx_t'(e))}};
      end
    end else if (pal_we) begin
      pal_q[index_q] <= pal_wdata;
    end
  end

  always_comb begin
    entry_t     ent;
    logic [7:0] lum;
    ent = pal_q[s1_col_q];
    lum = 8'({s1_col_q, s1_col_q});
    r_d = expand(ent[ENTRY_W-1 -: COMP_BITS]);
    g_d = expand(ent[2*COMP_BITS-1 -: COMP_BITS]);
    b_d = expand(ent[COMP_BITS-1:0]);
`ifdef MONO_TINT_EN
    unique case (mono_tint)
      2'b01: begin
        r_d = '0;
        g_d = lum;
        b_d = '0;
      end
      2'b10: begin
        r_d = lum;
        g_d = lum - (lum >> 2);
        b_d = '0;
      end
      2'b11: begin
        r_d = lum;
        g_d = lum;
        b_d = lum;
      end
      default: begin
        r_d = r_d;
      end
    endcase
`else
    if (lum == 8'hFF) begin
      r_d = r_d;
    end
`endif
    if (s1_hb_q || s1_vb_q) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1_col_q <= '0;
      s1_hs_q  <= 1'b0;
      s1_vs_q  <= 1'b0;
      s1_hb_q  <= 1'b1;
      s1_vb_q  <= 1'b1;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      hb_q     <= 1'b1;
      vb_q     <= 1'b1;
    end else if (ce_pix) begin
      s1_col_q <= colour;
      s1_hs_q  <= hsync_in;
      s1_vs_q  <= vsync_in;
      s1_hb_q  <= hb_in;
      s1_vb_q  <= vb_in;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      hs_q     <= s1_hs_q;
      vs_q     <= s1_vs_q;
      hb_q     <= s1_hb_q;
      vb_q     <= s1_vb_q;
    end
  end

  assign io_dout = dout_q;
  assign r       = r_q;
  assign g       = g_q;
  assign b       = b_q;
  assign hsync   = hs_q;
  assign vsync   = vs_q;
  assign hblank  = hb_q;
  assign vblank  = vb_q;

endmodule
